// File: rtl/rs_cmd_gen_pkg.sv
// Shared types and helpers for the RS-latch command generator.
package rs_cmd_gen_pkg;

    // FSM state encodings shared by the command generator and its users.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE_S = 2'd1,
        ST_PULSE_R = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // Channel indices for the per-button vectors.
    localparam int CH_S = 0;
    localparam int CH_R = 1;
    localparam int N_CH = 2;

    // Chooses which pulse to start from the pending flags; ST_IDLE when nothing is pending.
    function automatic state_t pick_pulse(
        input logic pend_s,
        input logic pend_r,
        input logic prio_reset
    );
        if (pend_r && (prio_reset || !pend_s)) begin
            return ST_PULSE_R;
        end
        if (pend_s) begin
            return ST_PULSE_S;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/rs_cmd_gen_debounce_cell.sv
// One button channel: 2-flop synchroniser, saturating debouncer and a
// single-cycle strobe on the accepted 0->1 transition of the debounced level.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW:0] C_TARGET = (CW + 1)'(DEBOUNCE_CYCLES);
    localparam logic [CW:0] C_ONE    = (CW + 1)'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_cnt_inc;
    logic          w_differs;
    logic          w_settle;

    // One extra bit on the increment so the comparison never sees a wrapped value.
    assign w_cnt_inc = {1'b0, r_cnt} + C_ONE;
    assign w_differs = (r_sync2 != r_db);
    // The sample has disagreed with db long enough: this edge accepts it.
    assign w_settle  = w_differs && (w_cnt_inc == C_TARGET);
    // Strobe is combinational so the pending flag loads on the same edge db changes.
    assign o_rise    = w_settle & r_sync2;

    // Synchronise the raw button and track how long the sample has differed from db.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_settle) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/rs_cmd_gen.sv
// Turns two bouncy push-buttons into clean, mutually exclusive, fixed-width
// set/reset pulses separated by at least one idle cycle, for an RS latch.
module rs_cmd_gen
    import rs_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter bit PRIO_RESET      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic busy
);

    localparam int PCW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PCW-1:0] C_PULSE_LOAD = PCW'(PULSE_CYCLES);
    localparam logic [PCW-1:0] C_PULSE_LAST = PCW'(1);

    logic [N_CH-1:0] w_btn;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_pend_clr;
    logic [N_CH-1:0] w_pend_next;
    logic [N_CH-1:0] r_pend;
    state_t          r_state;
    state_t          w_state_next;
    state_t          w_pick;
    logic [PCW-1:0]  r_cnt;
    logic [PCW-1:0]  w_cnt_next;
    logic            r_s;
    logic            r_r;

    assign w_btn[CH_S] = btn_s;
    assign w_btn[CH_R] = btn_r;

    // Per-channel debouncer and one-entry request flag; an edge while already
    // pending simply merges into the existing request.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .i_btn  (w_btn[gi]),
                .o_rise (w_rise[gi])
            );
            assign w_pend_next[gi] = w_rise[gi] | (r_pend[gi] & ~w_pend_clr[gi]);
        end
    endgenerate

    assign w_pick = pick_pulse(r_pend[CH_S], r_pend[CH_R], PRIO_RESET);

    // Next-state logic: GAP re-arbitrates directly so back-to-back pulses are
    // separated by exactly one idle cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pend_clr   = '0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_state_next = w_pick;
                w_cnt_next   = '0;
                if (w_pick == ST_PULSE_S) begin
                    w_cnt_next       = C_PULSE_LOAD;
                    w_pend_clr[CH_S] = 1'b1;
                end else if (w_pick == ST_PULSE_R) begin
                    w_cnt_next       = C_PULSE_LOAD;
                    w_pend_clr[CH_R] = 1'b1;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (r_cnt <= C_PULSE_LAST) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - C_PULSE_LAST;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, pulse counter, pending flags and registered latch drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pend  <= w_pend_next;
            r_s     <= (w_state_next == ST_PULSE_S);
            r_r     <= (w_state_next == ST_PULSE_R);
        end
    end

    assign s    = r_s;
    assign r    = r_r;
    assign busy = (r_state != ST_IDLE) | (|r_pend);

endmodule

// File: tb/tb_rs_cmd_gen.sv
// Directed bench for rs_cmd_gen: a scoreboard of expected pulses (kind, start
// edge, width) is filled as buttons are driven and drained as pulses complete.
module tb_rs_cmd_gen;

    localparam int DB  = 4;
    localparam int PW  = 3;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_s;
    logic btn_r;
    logic s1, r1, busy1;
    logic s0, r0, busy0;

    rs_cmd_gen #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PW),
        .PRIO_RESET     (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_s (btn_s),
        .btn_r (btn_r),
        .s     (s1),
        .r     (r1),
        .busy  (busy1)
    );

    rs_cmd_gen #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PW),
        .PRIO_RESET     (1'b0)
    ) dut_sp (
        .clk   (clk),
        .rst   (rst),
        .btn_s (btn_s),
        .btn_r (btn_r),
        .s     (s0),
        .r     (r0),
        .busy  (busy0)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic is_r;
        int   start;
        int   width;
    } pulse_t;

    pulse_t exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     start_s  = 0;
    int     start_r  = 0;
    logic   prev_s   = 1'b0;
    logic   prev_r   = 1'b0;
    logic   q        = 1'b0;
    logic   q0       = 1'b0;

    function automatic pulse_t mk(input logic is_r, input int st, input int w);
        pulse_t p;
        p.is_r  = is_r;
        p.start = st;
        p.width = w;
        return p;
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_done(input logic is_r, input int st, input int en);
        pulse_t got;
        pulse_t want;
        got = mk(is_r, st, en - st);
        $display("pulse %s start=%0d width=%0d", is_r ? "r" : "s", st, en - st);
        if (exp_q.size() == 0) begin
            check("pulse_unexpected", got, '0);
        end else begin
            want = exp_q.pop_front();
            check("pulse_kind_start_width", got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic until_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        check("s_r_exclusive", s1 & r1, 1'b0);
        check("s_r_exclusive_sp", s0 & r0, 1'b0);
        if (s1 && !prev_s) begin
            start_s = cyc;
            check("gap_before_s", prev_r, 1'b0);
        end
        if (r1 && !prev_r) begin
            start_r = cyc;
            check("gap_before_r", prev_s, 1'b0);
        end
        if (!s1 && prev_s) pulse_done(1'b0, start_s, cyc);
        if (!r1 && prev_r) pulse_done(1'b1, start_r, cyc);
        if (s1) q = 1'b1;
        else if (r1) q = 1'b0;
        if (s0) q0 = 1'b1;
        else if (r0) q0 = 1'b0;
        prev_s = s1;
        prev_r = r1;
    end

    int c;

    initial begin
        rst   = 1'b1;
        btn_s = 1'b0;
        btn_r = 1'b0;
        tick(3);
        check("reset_s", s1, 1'b0);
        check("reset_r", r1, 1'b0);
        check("reset_busy", busy1, 1'b0);
        check("reset_busy_sp", busy0, 1'b0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", busy1, 1'b0);

        // Clean set press, then clean reset press.
        c = cyc;
        btn_s = 1'b1;
        exp_q.push_back(mk(1'b0, c + LAT, PW));
        tick(12);
        check("clean_q_set", q, 1'b1);
        btn_s = 1'b0;
        tick(12);
        c = cyc;
        btn_r = 1'b1;
        exp_q.push_back(mk(1'b1, c + LAT, PW));
        tick(12);
        check("clean_q_reset", q, 1'b0);
        btn_r = 1'b0;
        tick(12);
        check("clean_drained", exp_q.size(), 0);

        // Bounce shorter than the debounce window.
        for (int k = 0; k < 4; k++) begin
            btn_s = (k % 2 == 0);
            tick(1);
            check("bounce_busy", busy1, 1'b0);
        end
        btn_s = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            check("bounce_busy", busy1, 1'b0);
            check("bounce_s", s1, 1'b0);
        end
        check("bounce_q", q, 1'b0);

        // Simultaneous presses: reset-priority instance via scoreboard,
        // set-priority instance checked cycle by cycle.
        c = cyc;
        btn_s = 1'b1;
        btn_r = 1'b1;
        exp_q.push_back(mk(1'b1, c + LAT, PW));
        exp_q.push_back(mk(1'b0, c + LAT + PW + 1, PW));
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check("prio0_s", s0, (cyc >= c + LAT) && (cyc < c + LAT + PW));
            check("prio0_r", r0, (cyc >= c + LAT + PW + 1) && (cyc < c + LAT + 2 * PW + 1));
        end
        check("simul_q_prio1", q, 1'b1);
        check("simul_q_prio0", q0, 1'b0);
        btn_s = 1'b0;
        btn_r = 1'b0;
        tick(12);
        check("simul_drained", exp_q.size(), 0);

        // Reset request lands during the second cycle of a set pulse.
        c = cyc;
        btn_s = 1'b1;
        exp_q.push_back(mk(1'b0, c + LAT, PW));
        until_cyc(c + 2);
        btn_r = 1'b1;
        exp_q.push_back(mk(1'b1, c + LAT + PW + 1, PW));
        for (int n = c + 3; n <= c + 16; n++) begin
            until_cyc(n);
            check("queued_busy", busy1, (n >= c + LAT - 1) && (n <= c + LAT + 2 * PW + 1));
        end
        btn_s = 1'b0;
        btn_r = 1'b0;
        tick(12);
        check("queued_drained", exp_q.size(), 0);

        // Reset mid-pulse with a reset request pending.
        c = cyc;
        btn_s = 1'b1;
        exp_q.push_back(mk(1'b0, c + LAT, 2));
        until_cyc(c + 2);
        btn_r = 1'b1;
        until_cyc(c + LAT + 1);
        check("rstmid_s_high", s1, 1'b1);
        check("rstmid_busy_high", busy1, 1'b1);
        rst   = 1'b1;
        btn_s = 1'b0;
        btn_r = 1'b0;
        until_cyc(c + LAT + 2);
        check("rstmid_s", s1, 1'b0);
        check("rstmid_r", r1, 1'b0);
        check("rstmid_busy", busy1, 1'b0);
        rst = 1'b0;
        tick(25);
        check("rstmid_no_r", exp_q.size(), 0);
        check("rstmid_idle", busy1, 1'b0);

        // Soak: set, hold, reset, hold.
        for (int it = 0; it < 5; it++) begin
            c = cyc;
            btn_s = 1'b1;
            exp_q.push_back(mk(1'b0, c + LAT, PW));
            tick(12);
            check("soak_q_set", q, 1'b1);
            btn_s = 1'b0;
            tick(12);
            c = cyc;
            btn_r = 1'b1;
            exp_q.push_back(mk(1'b1, c + LAT, PW));
            tick(12);
            check("soak_q_reset", q, 1'b0);
            btn_r = 1'b0;
            tick(12);
        end
        check("final_drained", exp_q.size(), 0);
        check("final_busy", busy1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
